// File: rtl/av_udp_pkg.sv
// av_udp_tx_ctrl shared definitions.
// Register offsets, STATUS bit positions, reset values, FSM encoding.
package av_udp_pkg;

  localparam int REG_SEND     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_IRQ_EN   = 2;
  localparam int REG_SENT     = 3;
  localparam int REG_CSUM     = 4;
  localparam int REG_CTX_BASE = 16;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_DONE  = 8;
  localparam int ST_OVF   = 9;
  localparam int ST_ERR   = 10;
  localparam int ST_LVL   = 16;

  localparam logic [15:0] RST_LPORT = 16'hFDEA;
  localparam logic [15:0] RST_RPORT = 16'hFDEB;
  localparam logic [31:0] RST_IP    = 32'hC0A8_0005;
  localparam logic [47:0] RST_MAC   = 48'hFFFF_FFFF_FFFF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    FSM_IDLE  = S_IDLE,
    FSM_OFFER = S_OFFER,
    FSM_WAIT  = S_WAIT
  } fsm_t;

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] len;
  } cmd_t;

endpackage

// File: rtl/udp_cmd_fifo.sv
// Synchronous command FIFO of {ch,len} entries with occupancy output.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module udp_cmd_fifo
  import av_udp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  cmd_t          wdata,
  input  logic          pop,
  output cmd_t          rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/av_udp_tx_ctrl.sv
// Avalon-MM front end for the UDP TX engine: per-channel contexts,
// command queue and a dispatcher that hands one packet at a time.
module av_udp_tx_ctrl
  import av_udp_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_done,
  output logic [3:0]        tx_ch,
  output logic [15:0]       tx_length,
  output logic [15:0]       tx_checksum,
  output logic [15:0]       tx_local_port,
  output logic [15:0]       tx_remote_port,
  output logic [31:0]       tx_remote_ip,
  output logic [47:0]       tx_remote_mac,
  output logic              irq
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fsm_t          state;
  logic [15:0]   lport  [NUM_CH];
  logic [15:0]   rport  [NUM_CH];
  logic [31:0]   rip    [NUM_CH];
  logic [31:0]   mac_lo [NUM_CH];
  logic [15:0]   mac_hi [NUM_CH];
  logic [15:0]   checksum;
  logic [31:0]   sent;
  logic [2:0]    sticky;
  logic [2:0]    irq_en;
  logic [2:0]    sticky_set;
  logic [2:0]    sticky_clr;
  logic [31:0]   rd_mux;
  logic [31:0]   rd_ctx;

  logic          hit_send, hit_status, hit_irqen;
  logic          hit_sent, hit_csum, hit_ctx;
  logic [ADDR_W-1:0] ctx_off;
  logic [CW-1:0] ctx_idx;

  cmd_t          send_cmd;
  logic          send_bad;
  logic          send_ok;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  cmd_t          fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] pop_idx;
  logic          done_set;

  assign ctx_off    = address - ADDR_W'(REG_CTX_BASE);
  assign ctx_idx    = ctx_off[CW+2:3];
  assign hit_send   = (address == ADDR_W'(REG_SEND));
  assign hit_status = (address == ADDR_W'(REG_STATUS));
  assign hit_irqen  = (address == ADDR_W'(REG_IRQ_EN));
  assign hit_sent   = (address == ADDR_W'(REG_SENT));
  assign hit_csum   = (address == ADDR_W'(REG_CSUM));
  assign hit_ctx    = (address >= ADDR_W'(REG_CTX_BASE))
                   && (int'(ctx_off[ADDR_W-1:3]) < NUM_CH)
                   && (ctx_off[2:0] <= 3'd4);

  assign send_cmd  = '{ch: writedata[3:0], len: writedata[31:16]};
  assign send_bad  = (send_cmd.len == '0) || (int'(send_cmd.ch) >= NUM_CH);
  assign send_ok   = write && hit_send && !send_bad;
  assign fifo_pop  = (state == FSM_IDLE) && !fifo_empty;
  assign fifo_push = send_ok;
  assign pop_idx   = fifo_rdata.ch[CW-1:0];
  assign done_set  = (state == FSM_WAIT) && tx_done;

  // sticky order {err, ovf, done} mirrors STATUS[10:8]
  assign sticky_set = {write && hit_send && send_bad,
                       send_ok && fifo_full && !fifo_pop,
                       done_set};
  assign sticky_clr = (write && hit_status) ? writedata[10:8] : 3'b000;

  assign tx_valid = (state == FSM_OFFER);
  assign irq      = |(sticky & irq_en);

  udp_cmd_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (send_cmd),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lport[i]  <= RST_LPORT;
        rport[i]  <= RST_RPORT;
        rip[i]    <= RST_IP;
        mac_lo[i] <= RST_MAC[31:0];
        mac_hi[i] <= RST_MAC[47:32];
      end
    end else if (write && hit_ctx) begin
      unique case (ctx_off[2:0])
        3'd0:    lport[ctx_idx]  <= writedata[15:0];
        3'd1:    rport[ctx_idx]  <= writedata[15:0];
        3'd2:    rip[ctx_idx]    <= writedata;
        3'd3:    mac_lo[ctx_idx] <= writedata;
        3'd4:    mac_hi[ctx_idx] <= writedata[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
      irq_en   <= '0;
      sticky   <= '0;
      sent     <= '0;
    end else begin
      if (write && hit_csum)  checksum <= writedata[15:0];
      if (write && hit_irqen) irq_en   <= writedata[10:8];
      sticky <= (sticky & ~sticky_clr) | sticky_set;
      if (write && hit_sent)  sent <= '0;
      else if (done_set)      sent <= sent + 32'd1;
    end
  end

  // context is snapshotted at pop so later channel writes miss the in-flight packet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FSM_IDLE;
      tx_ch          <= '0;
      tx_length      <= '0;
      tx_checksum    <= '0;
      tx_local_port  <= '0;
      tx_remote_port <= '0;
      tx_remote_ip   <= '0;
      tx_remote_mac  <= '0;
    end else begin
      unique case (state)
        FSM_IDLE: if (!fifo_empty) begin
          state          <= FSM_OFFER;
          tx_ch          <= fifo_rdata.ch;
          tx_length      <= fifo_rdata.len;
          tx_checksum    <= checksum;
          tx_local_port  <= lport[pop_idx];
          tx_remote_port <= rport[pop_idx];
          tx_remote_ip   <= rip[pop_idx];
          tx_remote_mac  <= {mac_hi[pop_idx], mac_lo[pop_idx]};
        end
        FSM_OFFER: if (tx_ready) state <= FSM_WAIT;
        FSM_WAIT:  if (tx_done)  state <= FSM_IDLE;
        default:   state <= FSM_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ctx = '0;
    unique case (ctx_off[2:0])
      3'd0:    rd_ctx = {16'h0, lport[ctx_idx]};
      3'd1:    rd_ctx = {16'h0, rport[ctx_idx]};
      3'd2:    rd_ctx = rip[ctx_idx];
      3'd3:    rd_ctx = mac_lo[ctx_idx];
      3'd4:    rd_ctx = {16'h0, mac_hi[ctx_idx]};
      default: rd_ctx = '0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_status: begin
        rd_mux[ST_BUSY]          = (state != FSM_IDLE);
        rd_mux[ST_FULL]          = fifo_full;
        rd_mux[ST_EMPTY]         = fifo_empty;
        rd_mux[ST_DONE]          = sticky[0];
        rd_mux[ST_OVF]           = sticky[1];
        rd_mux[ST_ERR]           = sticky[2];
        rd_mux[ST_LVL+7:ST_LVL]  = 8'(fifo_level);
      end
      hit_irqen: rd_mux[10:8]  = irq_en;
      hit_sent:  rd_mux        = sent;
      hit_csum:  rd_mux[15:0]  = checksum;
      hit_ctx:   rd_mux        = rd_ctx;
      default:   rd_mux        = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_av_udp_tx_ctrl.sv
// Self-checking bench for av_udp_tx_ctrl: scenario tasks plus a
// packet scoreboard filled at SEND time and drained at the handshake.
module tb_av_udp_tx_ctrl;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  address;
  logic        write, read;
  logic [31:0] writedata, readdata;
  logic        tx_valid, tx_ready, tx_done;
  logic [3:0]  tx_ch;
  logic [15:0] tx_length, tx_checksum, tx_local_port, tx_remote_port;
  logic [31:0] tx_remote_ip;
  logic [47:0] tx_remote_mac;
  logic        irq;
  logic        resp_done, man_done;

  assign tx_done = resp_done | man_done;

  always #5 clk = ~clk;

  av_udp_tx_ctrl #(.NUM_CH(NUM_CH), .FIFO_DEPTH(8), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .read(read), .writedata(writedata), .readdata(readdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_ch(tx_ch), .tx_length(tx_length), .tx_checksum(tx_checksum),
    .tx_local_port(tx_local_port), .tx_remote_port(tx_remote_port),
    .tx_remote_ip(tx_remote_ip), .tx_remote_mac(tx_remote_mac), .irq(irq)
  );

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] len;
    logic [15:0] csum;
    logic [15:0] lport;
    logic [15:0] rport;
    logic [31:0] ip;
    logic [47:0] mac;
  } pkt_t;

  pkt_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_pending = 0;
  bit          auto_done = 0;
  logic [15:0] m_lport [NUM_CH];
  logic [15:0] m_rport [NUM_CH];
  logic [31:0] m_ip    [NUM_CH];
  logic [47:0] m_mac   [NUM_CH];
  logic [15:0] m_csum;

  always @(negedge clk) begin
    pkt_t obs, exp;
    if (reset_n && tx_valid && tx_ready) begin
      obs = {tx_ch, tx_length, tx_checksum, tx_local_port,
             tx_remote_port, tx_remote_ip, tx_remote_mac};
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected got=%h", obs);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL pkt got=%h exp=%h", obs, exp);
        end
      end
      acc_pending++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (auto_done && acc_pending > 0) begin
      resp_done = 1'b1;
      acc_pending--;
    end else begin
      resp_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wr_ctx(input int ch, input int k, input logic [31:0] d);
    wr(8'(16 + 8 * ch + k), d);
    case (k)
      0: m_lport[ch] = d[15:0];
      1: m_rport[ch] = d[15:0];
      2: m_ip[ch]    = d;
      3: m_mac[ch][31:0]  = d;
      4: m_mac[ch][47:32] = d[15:0];
      default: ;
    endcase
  endtask

  task automatic send(input logic [3:0] ch, input logic [15:0] len, input bit pushed);
    wr(8'h00, {len, 12'h000, ch});
    if (pushed)
      sb.push_back({ch, len, m_csum, m_lport[ch[1:0]], m_rport[ch[1:0]],
                    m_ip[ch[1:0]], m_mac[ch[1:0]]});
  endtask

  task automatic drain(input int bound);
    int t = 0;
    while ((sb.size() != 0 || acc_pending != 0 || tx_valid) && t < bound) begin
      tick();
      t++;
    end
    n_chk++;
    if (t >= bound) begin
      n_fail++;
      $display("FAIL drain_timeout left=%0d pending=%0d", sb.size(), acc_pending);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; address = '0; write = 0; read = 0; writedata = '0;
    tx_ready = 0; resp_done = 0; man_done = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_lport[i] = 16'hFDEA; m_rport[i] = 16'hFDEB;
      m_ip[i] = 32'hC0A80005; m_mac[i] = 48'hFFFFFFFFFFFF;
    end
    m_csum = 16'h0;
    repeat (3) tick();
    n_chk++;
    if ({tx_valid, irq, tx_length, tx_remote_mac} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h", tx_valid, irq, tx_length, tx_remote_mac);
    end
    reset_n = 1'b1;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    rd(8'h1A, d); n_chk++;
    if (d !== 32'hC0A80005) begin n_fail++; $display("FAIL reset_ch1_ip got=%h exp=c0a80005", d); end
    rd(8'h01, d); n_chk++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status got=%h exp=4", d); end
    rd(8'h03, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL stray_done_sent got=%h exp=0", d); end
    rd(8'h2C, d); n_chk++;
    if (d !== 32'hFFFF) begin n_fail++; $display("FAIL reset_ch3_machi got=%h exp=ffff", d); end
    rd(8'h30, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    wr_ctx(2, 0, 32'h1111);
    wr_ctx(2, 1, 32'h2222);
    wr_ctx(2, 2, 32'h0A000002);
    wr_ctx(2, 3, 32'h33445566);
    wr_ctx(2, 4, 32'h0011);
    wr(8'h04, 32'hBEEF); m_csum = 16'hBEEF;
    tx_ready = 1'b1; auto_done = 1'b1;
    send(4'd2, 16'h0040, 1);
    n_chk++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid got=%b exp=0", tx_valid); end
    tick();
    n_chk++;
    if ({tx_valid, tx_ch, tx_length} !== {1'b1, 4'd2, 16'h0040}) begin
      n_fail++;
      $display("FAIL offer got=%b/%h/%h exp=1/2/0040", tx_valid, tx_ch, tx_length);
    end
    tick();
    n_chk++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop got=%b exp=0", tx_valid); end
    drain(50);
    rd(8'h03, d); n_chk++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL single_sent got=%0d exp=1", d); end
    rd(8'h01, d); n_chk++;
    if (d !== 32'h104) begin n_fail++; $display("FAIL single_status got=%h exp=104", d); end
    wr(8'h01, 32'h100);
    rd(8'h01, d); n_chk++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL done_w1c got=%h exp=4", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr(8'h03, 32'h5A5A);
    rd(8'h03, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL sent_clear got=%h exp=0", d); end
    tx_ready = 1'b0; auto_done = 1'b1;
    send(4'd0, 16'h0020, 1);
    tick();
    n_chk++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_first_offer got=%b exp=1", tx_valid); end
    for (int i = 0; i < 9; i++)
      send(4'(i % NUM_CH), 16'h0100 + 16'(i), i < 8);
    rd(8'h01, d); n_chk++;
    if (d !== 32'h0008_0203) begin n_fail++; $display("FAIL ovf_status got=%h exp=00080203", d); end
    wr(8'h01, 32'h200);
    tx_ready = 1'b1;
    drain(300);
    rd(8'h03, d); n_chk++;
    if (d !== 32'd9) begin n_fail++; $display("FAIL ovf_sent got=%0d exp=9", d); end
    wr(8'h01, 32'h100);
  endtask

  task automatic test_errors();
    logic [31:0] d;
    send(4'd1, 16'h0000, 0);
    rd(8'h01, d); n_chk++;
    if (d !== 32'h404) begin n_fail++; $display("FAIL err_len0 got=%h exp=404", d); end
    send(4'(NUM_CH), 16'h0005, 0);
    rd(8'h01, d); n_chk++;
    if (d !== 32'h404) begin n_fail++; $display("FAIL err_badch got=%h exp=404", d); end
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b exp=0", irq); end
    wr(8'h02, 32'h400);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_on got=%b exp=1", irq); end
    wr(8'h01, 32'h400);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
    rd(8'h01, d); n_chk++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL err_w1c got=%h exp=4", d); end
  endtask

  task automatic test_ctx_latch();
    logic [31:0] d;
    logic [15:0] old_rp;
    tx_ready = 1'b1; auto_done = 1'b0;
    old_rp = m_rport[0];
    send(4'd0, 16'h0033, 1);
    tick();
    tick();
    wr_ctx(0, 1, 32'h1234);
    tick();
    n_chk++;
    if (tx_remote_port !== old_rp) begin
      n_fail++;
      $display("FAIL ctx_latched got=%h exp=%h", tx_remote_port, old_rp);
    end
    man_done = 1'b1;
    wr(8'h01, 32'h100);
    man_done = 1'b0;
    acc_pending = 0;
    rd(8'h01, d); n_chk++;
    if (d !== 32'h104) begin n_fail++; $display("FAIL set_wins got=%h exp=104", d); end
    rd(8'h03, d); n_chk++;
    if (d !== 32'd10) begin n_fail++; $display("FAIL latch_sent got=%0d exp=10", d); end
    send(4'd0, 16'h0044, 1);
    tick();
    tick();
    man_done = 1'b1;
    wr(8'h03, 32'hFFFF);
    man_done = 1'b0;
    acc_pending = 0;
    rd(8'h03, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clear_wins got=%0d exp=0", d); end
    n_chk++;
    if (tx_remote_port !== 16'h1234) begin
      n_fail++;
      $display("FAIL ctx_new got=%h exp=1234", tx_remote_port);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_ready = 1'b0; auto_done = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i), 16'h0010 + 16'(i), 1);
    n_chk++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_offer got=%b exp=1", tx_valid); end
    rd(8'h01, d); n_chk++;
    if (d !== 32'h0003_0101) begin n_fail++; $display("FAIL mid_level got=%h exp=00030101", d); end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", tx_valid); end
    sb.delete();
    acc_pending = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd(8'h01, d); n_chk++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL post_reset_status got=%h exp=4", d); end
    rd(8'h03, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_sent got=%h exp=0", d); end
    rd(8'h22, d); n_chk++;
    if (d !== 32'hC0A80005) begin n_fail++; $display("FAIL post_reset_ip got=%h exp=c0a80005", d); end
    rd(8'h04, d); n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_csum got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_errors();
    test_ctx_latch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
